knight_scanner: RTL

//  Parametrised "knight rider" LED scanner: a lit head walks across N outputs

---
 rtl/knight_scanner_if.sv | 20 ++
 rtl/knight_scanner.sv | 138 +++++++++++++
 2 files changed

// File: rtl/knight_scanner_if.sv
// Purpose: control/status bundle between a knight_scanner and whoever drives it.
// Ports:   en/mode/div flow into the scanner; out/pos/dir/tick flow back.
// Modports: master = controller side, slave = scanner side.
interface knight_scanner_if #(
    parameter int N     = 8,
    parameter int DIV_W = 16
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic             en;
    logic [1:0]       mode;
    logic [DIV_W-1:0] div;
    logic [N-1:0]     out;
    logic [PW-1:0]    pos;
    logic             dir;
    logic             tick;

    modport master (output en, mode, div, input out, pos, dir, tick);
    modport slave  (input en, mode, div, output out, pos, dir, tick);
endinterface

// File: rtl/knight_scanner.sv
// Purpose: knight-rider LED scanner; a head plus TAIL-1 trailing segments walks
//          across N LEDs once per (div+1) enabled cycles in bounce/wrap/hold mode.
// Latency: pos, dir, tick and out all update on the clock edge that steps.
// Backpressure: none; en=0 freezes the prescaler and the head.
// Ports:   ck, res_n (async active-low); bus.slave carries en, mode, div in and
//          out, pos, dir, tick out.
// Option:  define TRAIL_FADE_EN to dim tail segment k to a 16>>k duty cycle
//          using a free-running 4-bit phase counter.
module knight_scanner #(
    parameter int N     = 8,
    parameter int TAIL  = 3,
    parameter int DIV_W = 16
) (
    input  logic              ck,
    input  logic              res_n,
    knight_scanner_if.slave   bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW-1:0] P_MAX = PW'(N - 1);
    localparam logic [PW-1:0] P_ONE = PW'(1);

    localparam logic [1:0] M_BOUNCE = 2'b00;
    localparam logic [1:0] M_UP     = 2'b01;
    localparam logic [1:0] M_DOWN   = 2'b10;

`ifdef TRAIL_FADE_EN
    localparam bit FADE = 1'b1;
`else
    localparam bit FADE = 1'b0;
`endif

    logic [DIV_W-1:0] cnt;
    logic [PW-1:0]    pos_q, pos_n;
    logic             dir_q, dir_n;
    logic [1:0]       mode_q, mode_n;   // mode latched at the last step; drives clip vs wrap
    logic             tick_q;
    logic [N-1:0]     out_q;
    logic [3:0]       ph_nx;
    logic             step;

    // Live compare: if div drops below cnt, cnt runs on to all-ones and wraps.
    assign step = bus.en && (cnt == bus.div);

`ifdef TRAIL_FADE_EN
    logic [3:0] ph;
    assign ph_nx = ph + 4'd1;

    always_ff @(posedge ck or negedge res_n) begin
        if (!res_n) ph <= 4'd0;
        else        ph <= ph_nx;
    end
`else
    assign ph_nx = 4'd0;
`endif

    // Lit-segment mask for a given head/direction/mode. Segment k trails the
    // head by k; wrap modes fold indices modulo N, other modes clip them.
    function automatic logic [N-1:0] seg_mask(input logic [PW-1:0] p,
                                              input logic          d,
                                              input logic [1:0]    m,
                                              input logic [3:0]    phase);
        logic [N-1:0] mk;
        int           idx;
        logic         wrap;
        logic         lit;
        mk   = '0;
        wrap = (m == M_UP) || (m == M_DOWN);
        for (int k = 0; k < TAIL; k++) begin
            idx = d ? (int'(p) - k) : (int'(p) + k);
            if (wrap) idx = ((idx % N) + N) % N;
            lit = (k == 0) || !FADE || (int'(phase) < (16 >> k));
            if (lit && idx >= 0 && idx < N) mk[idx[PW-1:0]] = 1'b1;
        end
        return mk;
    endfunction

    always_comb begin
        pos_n  = pos_q;
        dir_n  = dir_q;
        mode_n = mode_q;
        if (step) begin
            mode_n = bus.mode;
            case (bus.mode)
                M_BOUNCE: begin
                    // Turn around on the end itself so each end is shown for one step only.
                    if (dir_q) begin
                        if (pos_q == P_MAX) begin
                            pos_n = P_MAX - P_ONE;
                            dir_n = 1'b0;
                        end else begin
                            pos_n = pos_q + P_ONE;
                        end
                    end else begin
                        if (pos_q == '0) begin
                            pos_n = P_ONE;
                            dir_n = 1'b1;
                        end else begin
                            pos_n = pos_q - P_ONE;
                        end
                    end
                end
                M_UP: begin
                    dir_n = 1'b1;
                    pos_n = (pos_q == P_MAX) ? '0 : pos_q + P_ONE;
                end
                M_DOWN: begin
                    dir_n = 1'b0;
                    pos_n = (pos_q == '0) ? P_MAX : pos_q - P_ONE;
                end
                default: ;  // hold: head frozen, tick still pulses
            endcase
        end
    end

    always_ff @(posedge ck or negedge res_n) begin
        if (!res_n) begin
            cnt    <= '0;
            pos_q  <= '0;
            dir_q  <= 1'b1;
            mode_q <= M_BOUNCE;
            tick_q <= 1'b0;
            out_q  <= {{(N-1){1'b0}}, 1'b1};
        end else begin
            tick_q <= step;
            if (bus.en) cnt <= step ? '0 : cnt + 1'b1;
            pos_q  <= pos_n;
            dir_q  <= dir_n;
            mode_q <= mode_n;
            // Built from next-state values so out moves on the same edge as pos.
            out_q  <= seg_mask(pos_n, dir_n, mode_n, ph_nx);
        end
    end

    assign bus.out  = out_q;
    assign bus.pos  = pos_q;
    assign bus.dir  = dir_q;
    assign bus.tick = tick_q;
endmodule
